// File: rtl/timebase_pkg.sv
// rtl/timebase_pkg.sv - shared constants and helpers for the stopwatch timebase
package timebase_pkg;

    localparam int DEFAULT_BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000;
    localparam int DEFAULT_BASE_TICK_FREQUENCY_IN_HZ   = 1000;
    localparam int DEFAULT_NUM_STAGES                  = 4;
    localparam int DEFAULT_STAGE_RATIO                 = 10;

    function automatic int prescale_of(input int board_hz, input int base_hz);
        if (base_hz < 1) begin
            return 0;
        end
        return board_hz / base_hz;
    endfunction

    // Non-zero only when the board clock divides down to the base rate exactly.
    function automatic bit prescale_valid(input int board_hz, input int base_hz);
        if (base_hz < 1) begin
            return 1'b0;
        end
        if ((board_hz % base_hz) != 0) begin
            return 1'b0;
        end
        return (board_hz / base_hz) >= 2;
    endfunction

    function automatic int width_of(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/timebase_stage.sv
// rtl/timebase_stage.sv - mod-RATIO counter stage with combinational carry out
module timebase_stage
    import timebase_pkg::*;
#(
    parameter int RATIO = DEFAULT_STAGE_RATIO
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic carry_in,
    output logic carry_out
);

    localparam int W = width_of(RATIO);
    localparam logic [W-1:0] LAST = W'(RATIO - 1);

    logic [W-1:0] cnt;
    logic         at_last;

    assign at_last   = (cnt == LAST);
    assign carry_out = carry_in && at_last;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (carry_in) begin
            cnt <= at_last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_timebase.sv
// rtl/stopwatch_timebase.sv - pausable prescaler with cascaded aligned tick stages
module stopwatch_timebase
    import timebase_pkg::*;
#(
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = DEFAULT_BOARD_CLOCK_FREQUENCY_IN_HZ,
    parameter int BASE_TICK_FREQUENCY_IN_HZ   = DEFAULT_BASE_TICK_FREQUENCY_IN_HZ,
    parameter int NUM_STAGES                  = DEFAULT_NUM_STAGES,
    parameter int STAGE_RATIO                 = DEFAULT_STAGE_RATIO
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  clear,
    input  logic                  step,
    output logic [NUM_STAGES-1:0] tick,
    output logic [NUM_STAGES-1:0] square
);

    localparam int PRESCALE = prescale_of(BOARD_CLOCK_FREQUENCY_IN_HZ, BASE_TICK_FREQUENCY_IN_HZ);
    localparam int CW       = width_of(PRESCALE);
    localparam logic [CW-1:0] COUNT_LAST = CW'(PRESCALE - 1);

    if (!prescale_valid(BOARD_CLOCK_FREQUENCY_IN_HZ, BASE_TICK_FREQUENCY_IN_HZ)) begin : g_bad_prescale
        $error("stopwatch_timebase: board clock must divide exactly into base tick with ratio >= 2");
    end
    if (NUM_STAGES < 1) begin : g_bad_stages
        $error("stopwatch_timebase: NUM_STAGES must be >= 1");
    end
    if (STAGE_RATIO < 2) begin : g_bad_ratio
        $error("stopwatch_timebase: STAGE_RATIO must be >= 2");
    end

    logic [CW-1:0]         count;
    logic                  count_at_last;
    logic [NUM_STAGES-1:0] carry;

    assign count_at_last = (count == COUNT_LAST);

    // A step only counts while paused; when running the prescaler alone decides.
    assign carry[0] = run ? count_at_last : step;

    for (genvar k = 1; k < NUM_STAGES; k++) begin : g_stage
        timebase_stage #(
            .RATIO(STAGE_RATIO)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear),
            .carry_in (carry[k-1]),
            .carry_out(carry[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count  <= '0;
            tick   <= '0;
            square <= '0;
        end else begin
            if (run) begin
                count <= count_at_last ? '0 : count + 1'b1;
            end
            tick   <= carry;
            square <= square ^ carry;
        end
    end

endmodule

// File: tb/tb_stopwatch_timebase.sv
// tb/tb_stopwatch_timebase.sv - scoreboard bench for stopwatch_timebase
module tb_stopwatch_timebase;

    localparam int NS = 3;
    localparam int R  = 3;
    localparam int P  = 5;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          run   = 1'b0;
    logic          clear = 1'b0;
    logic          step  = 1'b0;
    logic [NS-1:0] tick;
    logic [NS-1:0] square;

    stopwatch_timebase #(
        .BOARD_CLOCK_FREQUENCY_IN_HZ(10),
        .BASE_TICK_FREQUENCY_IN_HZ  (2),
        .NUM_STAGES                 (NS),
        .STAGE_RATIO                (R)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .clear (clear),
        .step  (step),
        .tick  (tick),
        .square(square)
    );

    always #1 clk = ~clk;

    int npass  = 0;
    int ntotal = 0;
    int edge_n = 0;
    int m_pc   = 0;
    int m_b    = 0;

    logic [2*NS-1:0] sb[$];
    logic [NS-1:0]   tick_hist[256];
    logic [NS-1:0]   sq_hist[256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
    endtask

    // Expected outputs come from base-tick arithmetic: tick[k] fires when the
    // base tick count is a multiple of R^k, square[k] is the parity of b / R^k.
    task automatic cyc(input logic r, input logic c, input logic rn, input logic st);
        logic          fire;
        logic [NS-1:0] et;
        logic [NS-1:0] es;
        logic [2*NS-1:0] e;
        int            div;
        rst   = r;
        clear = c;
        run   = rn;
        step  = st;
        et    = '0;
        if (r || c) begin
            m_pc = 0;
            m_b  = 0;
        end else begin
            fire = rn ? (m_pc == P - 1) : st;
            if (rn) m_pc = (m_pc == P - 1) ? 0 : m_pc + 1;
            if (fire) m_b++;
            div = 1;
            for (int k = 0; k < NS; k++) begin
                et[k] = fire && ((m_b % div) == 0);
                div   = div * R;
            end
        end
        div = 1;
        for (int k = 0; k < NS; k++) begin
            es[k] = ((m_b / div) % 2) == 1;
            div   = div * R;
        end
        sb.push_back({et, es});
        @(posedge clk);
        @(negedge clk);
        edge_n++;
        e = sb.pop_front();
        check("tick", 32'(tick), 32'(e[2*NS-1:NS]));
        check("square", 32'(square), 32'(e[NS-1:0]));
        if (edge_n < 256) begin
            tick_hist[edge_n] = tick;
            sq_hist[edge_n]   = square;
        end
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        edge_n = 0;
        for (int i = 0; i < 256; i++) begin
            tick_hist[i] = '0;
            sq_hist[i]   = '0;
        end
    endtask

    function automatic int first_t(input int k, input int from);
        for (int e = from; e < 256; e++) begin
            if (tick_hist[e][k]) return e;
        end
        return -1;
    endfunction

    function automatic int count_t(input int k, input int from, input int to);
        int n = 0;
        for (int e = from; e <= to; e++) begin
            if (tick_hist[e][k]) n++;
        end
        return n;
    endfunction

    initial begin
        // reset with run and step held high
        do_reset();
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_square", 32'(square), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("release_tick", 32'(tick), 32'd0);

        // free run
        for (int e = 2; e <= 50; e++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("free_t0_first", 32'(first_t(0, 1)), 32'd5);
        check("free_t0_second", 32'(first_t(0, 6)), 32'd10);
        check("free_t0_count", 32'(count_t(0, 1, 50)), 32'd10);
        check("free_t1_first", 32'(first_t(1, 1)), 32'd15);
        check("free_t1_second", 32'(first_t(1, 16)), 32'd30);
        check("free_t2_first", 32'(first_t(2, 1)), 32'd45);
        check("free_sq0_before", 32'(sq_hist[4][0]), 32'd0);
        check("free_sq0_rise", 32'(sq_hist[5][0]), 32'd1);
        check("free_sq0_fall", 32'(sq_hist[10][0]), 32'd0);

        // pause for edges 7..16
        do_reset();
        for (int e = 1; e <= 100; e++) cyc(1'b0, 1'b0, !(e >= 7 && e <= 16), 1'b0);
        check("pause_next_t0", 32'(first_t(0, 6)), 32'd20);
        check("pause_t0_count", 32'(count_t(0, 1, 100)), 32'd18);

        // single steps while paused, sampled at edges 4, 7, 10
        do_reset();
        for (int e = 1; e <= 12; e++) cyc(1'b0, 1'b0, 1'b0, (e == 4 || e == 7 || e == 10));
        check("step_t0_a", 32'(tick_hist[4][0]), 32'd1);
        check("step_t0_b", 32'(tick_hist[7][0]), 32'd1);
        check("step_t0_c", 32'(tick_hist[10][0]), 32'd1);
        check("step_t1", 32'(tick_hist[10][1]), 32'd1);
        check("step_t0_count", 32'(count_t(0, 1, 12)), 32'd3);
        for (int e = 13; e <= 15; e++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("step_hold_count", 32'(count_t(0, 13, 15)), 32'd3);
        for (int e = 16; e <= 22; e++) cyc(1'b0, 1'b0, 1'b1, (e == 17));
        check("step_resume_t0", 32'(first_t(0, 16)), 32'd20);
        check("step_run_ignored", 32'(count_t(0, 16, 19)), 32'd0);

        // clear collides with a due tick at edge 5
        do_reset();
        for (int e = 1; e <= 4; e++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check("clear_no_tick", 32'(tick), 32'd0);
        check("clear_square", 32'(square), 32'd0);
        for (int e = 6; e <= 25; e++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("clear_next_t0", 32'(first_t(0, 6)), 32'd10);
        check("clear_next_t1", 32'(first_t(1, 6)), 32'd20);

        // reset in the middle of a run
        do_reset();
        for (int e = 1; e <= 46; e++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("mid_sq2_set", 32'(sq_hist[46][2]), 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        check("mid_rst_tick", 32'(tick), 32'd0);
        check("mid_rst_square", 32'(square), 32'd0);
        for (int e = 48; e <= 58; e++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("mid_first_t0", 32'(first_t(0, 48)), 32'd52);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
